// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - direct-mapped write-back/write-allocate data cache controller
// Optional CACHE_STATS_EN adds saturating hit_count/miss_count outputs.
module cache_controller #(
  parameter int NUM_BLOCKS  = 4,
  parameter int MEM_LATENCY = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         cpu_req,
  input  logic         cpu_read_write,
  input  logic [9:0]   cpu_address,
  input  logic [31:0]  cpu_write_data,
  output logic [31:0]  cpu_read_data,
  output logic         cpu_done,
  output logic         cpu_busy,
  output logic         mem_read_write,
  output logic [9:0]   mem_address,
  output logic [127:0] mem_write_data,
  input  logic [127:0] mem_read_data
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]  hit_count,
  output logic [15:0]  miss_count
`endif
);

  localparam int IDX_W = $clog2(NUM_BLOCKS);
  localparam int TAG_W = 6 - IDX_W;
  localparam int CNT_W = $clog2(MEM_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, COMPARE, WRITE_BACK, ALLOCATE} state_t;

  state_t state, next_state;

  logic [9:2]       req_addr;
  logic             req_rw;
  logic [31:0]      req_wdata;
  logic [CNT_W-1:0] cnt;
  logic [NUM_BLOCKS-1:0] valid;
  logic [NUM_BLOCKS-1:0] dirty;
  logic [TAG_W-1:0] tag_mem   [NUM_BLOCKS];
  logic [127:0]     line_data [NUM_BLOCKS];

  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [1:0]       req_word;
  logic             hit;
  logic             cnt_done;
  logic [127:0]     evict_block;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^cpu_address[1:0];
  assign req_idx  = req_addr[4 +: IDX_W];
  assign req_tag  = req_addr[9 -: TAG_W];
  assign req_word = req_addr[3:2];
  assign hit      = valid[req_idx] && (tag_mem[req_idx] == req_tag);
  assign cnt_done = (cnt == CNT_W'(MEM_LATENCY - 1));

  // Eviction packs words in reverse order relative to fills.
  always_comb begin
    evict_block = '0;
    for (int k = 0; k < 4; k++)
      evict_block[127-32*k -: 32] = line_data[req_idx][32*k +: 32];
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:       if (cpu_req) next_state = COMPARE;
      COMPARE:    if (hit) next_state = IDLE;
                  else if (dirty[req_idx]) next_state = WRITE_BACK;
                  else next_state = ALLOCATE;
      WRITE_BACK: if (cnt_done) next_state = ALLOCATE;
      ALLOCATE:   if (cnt_done) next_state = COMPARE;
      default:    next_state = IDLE;
    endcase
  end

  always_comb begin
    mem_read_write = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    if (state == WRITE_BACK) begin
      mem_read_write = 1'b1;
      mem_address    = {tag_mem[req_idx], req_idx, 4'b0};
      mem_write_data = evict_block;
    end else if (state == ALLOCATE) begin
      mem_address    = {req_tag, req_idx, 4'b0};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      req_addr      <= '0;
      req_rw        <= 1'b0;
      req_wdata     <= '0;
      cnt           <= '0;
      valid         <= '0;
      dirty         <= '0;
      cpu_read_data <= '0;
      cpu_done      <= 1'b0;
      cpu_busy      <= 1'b0;
    end else begin
      state    <= next_state;
      cpu_done <= 1'b0;
      if (next_state != state) cnt <= '0;
      else if (state == WRITE_BACK || state == ALLOCATE) cnt <= cnt + 1'b1;
      case (state)
        IDLE: if (cpu_req) begin
          req_addr  <= cpu_address[9:2];
          req_rw    <= cpu_read_write;
          req_wdata <= cpu_write_data;
          cpu_busy  <= 1'b1;
        end
        COMPARE: if (hit) begin
          cpu_done <= 1'b1;
          cpu_busy <= 1'b0;
          if (req_rw) dirty[req_idx] <= 1'b1;
          else cpu_read_data <= line_data[req_idx][{req_word, 5'b0} +: 32];
        end
        WRITE_BACK: if (cnt_done) dirty[req_idx] <= 1'b0;
        ALLOCATE: if (cnt_done) begin
          valid[req_idx] <= 1'b1;
          dirty[req_idx] <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Line data and tags need no reset; valid bits gate their use.
  always_ff @(posedge clock) begin
    if (state == COMPARE && hit && req_rw)
      line_data[req_idx][{req_word, 5'b0} +: 32] <= req_wdata;
    if (state == ALLOCATE && cnt_done) begin
      line_data[req_idx] <= mem_read_data;
      tag_mem[req_idx]   <= req_tag;
    end
  end

`ifdef CACHE_STATS_EN
  logic fill_pass;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fill_pass  <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (state == ALLOCATE && cnt_done) fill_pass <= 1'b1;
      else if (state == COMPARE) fill_pass <= 1'b0;
      // The COMPARE revisited after a fill is the same access, not a new hit.
      if (state == COMPARE && !fill_pass) begin
        if (hit) begin
          if (hit_count != 16'hFFFF) hit_count <= hit_count + 1'b1;
        end else if (miss_count != 16'hFFFF) begin
          miss_count <= miss_count + 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_controller.sv
// tb/tb_cache_controller.sv - scoreboard bench for cache_controller with a 1 KB memory model
module tb_cache_controller;

  logic         clock = 1'b0;
  logic         reset;
  logic         cpu_req;
  logic         cpu_read_write;
  logic [9:0]   cpu_address;
  logic [31:0]  cpu_write_data;
  logic [31:0]  cpu_read_data;
  logic         cpu_done;
  logic         cpu_busy;
  logic         mem_read_write;
  logic [9:0]   mem_address;
  logic [127:0] mem_write_data;
  logic [127:0] mem_read_data;
`ifdef CACHE_STATS_EN
  logic [15:0]  hit_count;
  logic [15:0]  miss_count;
`endif

  cache_controller #(.NUM_BLOCKS(4), .MEM_LATENCY(4)) dut (
    .clock(clock), .reset(reset), .cpu_req(cpu_req), .cpu_read_write(cpu_read_write),
    .cpu_address(cpu_address), .cpu_write_data(cpu_write_data), .cpu_read_data(cpu_read_data),
    .cpu_done(cpu_done), .cpu_busy(cpu_busy), .mem_read_write(mem_read_write),
    .mem_address(mem_address), .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
`ifdef CACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        chk_data;
    logic [31:0] data;
    int          cycle;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int commits = 0;
  logic [31:0] mem [256];
  logic        tr_rw   [40];
  logic [9:0]  tr_addr [40];
  logic [31:0] tr_wd   [40];
  logic        tr_busy [40];

  always @(posedge clock) cycle <= cycle + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always_comb begin
    for (int k = 0; k < 4; k++)
      mem_read_data[32*k +: 32] = mem[{mem_address[9:4], 2'(k)}];
  end

  always @(posedge mem_read_write) begin
    #1;
    commits++;
    for (int k = 0; k < 4; k++)
      mem[{mem_address[9:4], 2'(k)}] = mem_write_data[127-32*k -: 32];
  end

  always @(negedge clock) begin
    if (cpu_done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1'b1, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.chk_data) check("read_data", cpu_read_data, e.data);
        check("done_latency", cycle, e.cycle);
        check("busy_at_done", cpu_busy, 1'b0);
      end
    end
  end

  task automatic issue(input logic [9:0] addr, input logic rw, input logic [31:0] wd,
                       input logic [31:0] exp, input int lat);
    exp_t e;
    logic got_done;
    @(negedge clock);
    cpu_address = addr; cpu_read_write = rw; cpu_write_data = wd; cpu_req = 1'b1;
    @(posedge clock);
    #1 cpu_req = 1'b0;
    e.chk_data = !rw; e.data = exp; e.cycle = cycle + lat;
    sb.push_back(e);
    got_done = 1'b0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clock);
      tr_rw[j] = mem_read_write; tr_addr[j] = mem_address;
      tr_wd[j] = mem_write_data[63:32]; tr_busy[j] = cpu_busy;
      if (cpu_done) begin
        got_done = 1'b1;
        break;
      end
    end
    check("done_seen", got_done, 1'b1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_done"}, cpu_done, 1'b0);
    check({tag, "_busy"}, cpu_busy, 1'b0);
    check({tag, "_rdata"}, cpu_read_data, 32'h0);
    check({tag, "_mem_rw"}, mem_read_write, 1'b0);
    check({tag, "_mem_addr"}, mem_address, 10'h0);
    check({tag, "_mem_wdata"}, mem_write_data, 128'h0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = i;
    reset = 1'b1; cpu_req = 1'b0; cpu_read_write = 1'b0;
    cpu_address = '0; cpu_write_data = '0;
    repeat (3) @(negedge clock);
    check_idle_outputs("reset");
    #1 reset = 1'b0;

    // Clean miss on block 0
    issue(10'h004, 1'b0, 32'h0, 32'h0000_0001, 6);
    check("miss_busy", tr_busy[0], 1'b1);
    for (int j = 1; j <= 4; j++) begin
      check("alloc_rw", tr_rw[j], 1'b0);
      check("alloc_addr", tr_addr[j], 10'h000);
    end
    check("no_commit_clean", commits, 0);

    issue(10'h004, 1'b0, 32'h0, 32'h0000_0001, 1);
    check("hit_mem_rw", tr_rw[0], 1'b0);

    issue(10'h008, 1'b1, 32'hDEAD_BEEF, 32'h0, 1);
    issue(10'h008, 1'b0, 32'h0, 32'hDEAD_BEEF, 1);
    check("mem_word2_unchanged", mem[2], 32'h0000_0002);

    // Dirty eviction of block 0 then fill from 0x040
    issue(10'h048, 1'b0, 32'h0, 32'h0000_0012, 10);
    for (int j = 1; j <= 4; j++) begin
      check("wb_rw", tr_rw[j], 1'b1);
      check("wb_addr", tr_addr[j], 10'h000);
      check("wb_data", tr_wd[j], 32'hDEAD_BEEF);
    end
    for (int j = 5; j <= 8; j++) begin
      check("fill_rw", tr_rw[j], 1'b0);
      check("fill_addr", tr_addr[j], 10'h040);
    end
    check("post_fill_addr", tr_addr[9], 10'h000);
    check("commit_count", commits, 1);
    check("mem_word2_written", mem[2], 32'hDEAD_BEEF);

`ifdef CACHE_STATS_EN
    check("hit_count", hit_count, 16'd3);
    check("miss_count", miss_count, 16'd2);
`endif

    // Reset during the second ALLOCATE cycle aborts the fill
    @(negedge clock);
    cpu_address = 10'h100; cpu_read_write = 1'b0; cpu_req = 1'b1;
    @(posedge clock);
    #1 cpu_req = 1'b0;
    repeat (3) @(negedge clock);
    check("abort_alloc_addr", mem_address, 10'h100);
    reset = 1'b1;
    #1;
    check_idle_outputs("abort");
`ifdef CACHE_STATS_EN
    check("abort_hit_count", hit_count, 16'd0);
    check("abort_miss_count", miss_count, 16'd0);
`endif
    @(negedge clock);
    #1 reset = 1'b0;

    issue(10'h100, 1'b0, 32'h0, 32'h0000_0040, 6);
    check("commit_after_abort", commits, 1);

    repeat (3) @(negedge clock);
    check("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
